// File: rtl/latency_meter_pkg.sv
// Shared types for the glass-to-glass latency meter.
package latency_meter_pkg;

    typedef enum logic [2:0] {
        LM_IDLE,
        LM_DARK,
        LM_FLASH,
        LM_RECORD,
        LM_FINISH
    } lm_state_t;

endpackage

// File: rtl/us_ticker.sv
// Microsecond prescaler: one-cycle tick every US_DIV cycles, phase reset by clear.
module us_ticker #(
    parameter int US_DIV = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int PW = (US_DIV > 2) ? $clog2(US_DIV) : 1;

    logic [PW-1:0] pre;

    assign tick = (pre == PW'(US_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || clear || tick) begin
            pre <= '0;
        end else begin
            pre <= pre + PW'(1);
        end
    end

endmodule

// File: rtl/latency_meter.sv
// Flashes the test pattern white and times the sensor response in microseconds,
// reporting last/avg/min/max over batches of 2^AVG_LOG2 samples.
module latency_meter
    import latency_meter_pkg::*;
#(
    parameter int US_DIV     = 100,
    parameter int CNT_W      = 20,
    parameter int AVG_LOG2   = 3,
    parameter int SETTLE_US  = 50_000,
    parameter int TIMEOUT_US = 500_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic                continuous,
    input  logic                light_on,
    output logic                flash,
    output logic                busy,
    output logic                done,
    output logic                timeout,
    output logic [CNT_W-1:0]    latency_last,
    output logic [CNT_W-1:0]    latency_avg,
    output logic [CNT_W-1:0]    latency_min,
    output logic [CNT_W-1:0]    latency_max,
    output logic [AVG_LOG2:0]   sample_idx
);

    localparam int ACC_W = CNT_W + AVG_LOG2;
    localparam int IDX_W = AVG_LOG2 + 1;
    localparam int NSAMP = 1 << AVG_LOG2;

    lm_state_t        state, state_nxt;
    logic             tick, clear;
    logic             set_timeout, batch_init;
    logic             settled, hit_timeout, last_sample;
    logic [CNT_W-1:0] us_cnt, cnt_inc;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [CNT_W-1:0] run_min, run_max, min_nxt, max_nxt;

    // Every state entry restarts the prescaler phase and the µs count.
    assign clear = (state_nxt != state);

    us_ticker #(.US_DIV(US_DIV)) u_ticker (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .tick  (tick)
    );

    assign cnt_inc     = (tick && (us_cnt != '1)) ? us_cnt + CNT_W'(1) : us_cnt;
    assign settled     = (us_cnt >= CNT_W'(SETTLE_US));
    assign hit_timeout = (cnt_inc == CNT_W'(TIMEOUT_US));
    assign last_sample = (sample_idx == IDX_W'(NSAMP - 1));

    assign acc_nxt = acc + ACC_W'(latency_last);
    assign min_nxt = (latency_last < run_min) ? latency_last : run_min;
    assign max_nxt = (latency_last > run_max) ? latency_last : run_max;

    always_comb begin
        state_nxt   = state;
        set_timeout = 1'b0;
        batch_init  = 1'b0;
        if (abort) begin
            state_nxt = LM_IDLE;
        end else begin
            case (state)
                LM_IDLE: begin
                    if (start) begin
                        state_nxt  = LM_DARK;
                        batch_init = 1'b1;
                    end
                end
                LM_DARK: begin
                    if (settled && !light_on) begin
                        state_nxt = LM_FLASH;
                    end else if (hit_timeout) begin
                        state_nxt   = LM_IDLE;
                        set_timeout = 1'b1;
                    end
                end
                LM_FLASH: begin
                    if (light_on) begin
                        state_nxt = LM_RECORD;
                    end else if (hit_timeout) begin
                        state_nxt   = LM_IDLE;
                        set_timeout = 1'b1;
                    end
                end
                LM_RECORD: state_nxt = last_sample ? LM_FINISH : LM_DARK;
                LM_FINISH: begin
                    if (continuous) begin
                        state_nxt  = LM_DARK;
                        batch_init = 1'b1;
                    end else begin
                        state_nxt = LM_IDLE;
                    end
                end
                default: state_nxt = LM_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= LM_IDLE;
            us_cnt       <= '0;
            acc          <= '0;
            run_min      <= '0;
            run_max      <= '0;
            flash        <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            latency_last <= '0;
            latency_avg  <= '0;
            latency_min  <= '0;
            latency_max  <= '0;
            sample_idx   <= '0;
        end else begin
            state  <= state_nxt;
            flash  <= (state_nxt == LM_FLASH);
            busy   <= (state_nxt != LM_IDLE);
            done   <= 1'b0;
            us_cnt <= (clear || state == LM_IDLE) ? '0 : cnt_inc;

            if (set_timeout) begin
                timeout <= 1'b1;
            end else if (batch_init) begin
                timeout <= 1'b0;
            end

            if (batch_init) begin
                acc        <= '0;
                sample_idx <= '0;
                run_min    <= '1;
                run_max    <= '0;
            end

            if (state == LM_FLASH && light_on && !abort) begin
                latency_last <= us_cnt;
            end

            // Published results only change on a batch that ran to completion.
            if (state == LM_RECORD && !abort) begin
                acc        <= acc_nxt;
                run_min    <= min_nxt;
                run_max    <= max_nxt;
                sample_idx <= sample_idx + IDX_W'(1);
                if (last_sample) begin
                    latency_avg <= CNT_W'(acc_nxt >> AVG_LOG2);
                    latency_min <= min_nxt;
                    latency_max <= max_nxt;
                    done        <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/latency_meter.md
# latency_meter

Automated glass-to-glass latency measurement engine for the video delay tester. It drives a `flash` request that switches the DVI pattern from dark to full white, then times in microseconds how long the photodiode path takes to report light. It averages 2^AVG_LOG2 samples per batch and tracks min/max, in single-shot or continuous mode. It sits between the light-sensor path and the pattern selector, and its results feed the seven-segment display.

## Interface
Parameters:
- `US_DIV`, 100: `clk` cycles per microsecond tick (≥2).
- `CNT_W`, 20: width of latency counters in µs.
- `AVG_LOG2`, 3: log2 of samples per batch (0..6).
- `SETTLE_US`, 50_000: dark time before each flash, in µs.
- `TIMEOUT_US`, 500_000: maximum wait in DARK or FLASH, in µs (< 2^CNT_W).

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a batch; ignored unless idle.
- `abort` in 1: one-cycle pulse that returns the block to IDLE.
- `continuous` in 1: sampled at batch end; 1 restarts a new batch automatically.
- `light_on` in 1: synchronised, debounced sensor level.
- `flash` out 1: 1 selects the white pattern; 0 selects black.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when a batch completes; averages are valid.
- `timeout` out 1: sticky error flag; cleared by `start` or `reset`.
- `latency_last` out CNT_W: most recent sample.
- `latency_avg` out CNT_W: mean of the last completed batch.
- `latency_min` out CNT_W: minimum of the last completed batch.
- `latency_max` out CNT_W: maximum of the last completed batch.
- `sample_idx` out AVG_LOG2+1: samples taken in the current batch.

## Operation
- States: IDLE, DARK, FLASH, RECORD, FINISH.
- IDLE: `flash`=0. On `start`, clear the accumulator and `sample_idx`, set running min to all-ones and running max to 0, clear `timeout`, then go to DARK.
- DARK: `flash`=0 and the µs counter runs.
  - After SETTLE_US ticks with `light_on`=0, clear the counter and go to FLASH.
  - If `light_on` is still 1 once SETTLE_US is reached, keep waiting.
  - If the counter reaches TIMEOUT_US, set `timeout` and go to IDLE.
- FLASH: `flash`=1 and the counter counts from 0.
  - On the first cycle `light_on`=1, latch the counter into `latency_last` and go to RECORD.
  - If the counter reaches TIMEOUT_US first, set `timeout` and go to IDLE.
- RECORD (1 cycle): `flash` drops to 0.
  - Add the sample to the accumulator (width CNT_W+AVG_LOG2, no overflow possible).
  - Update running min/max and increment `sample_idx`.
  - If `sample_idx` reaches 2^AVG_LOG2, go to FINISH; otherwise go to DARK with the counter cleared.
- FINISH (1 cycle):
  - `latency_avg` = accumulator >> AVG_LOG2, truncated.
  - Copy running min/max to the outputs and pulse `done`.
  - If `continuous`=1, reinitialise as for `start` (leaving the outputs held) and go to DARK; otherwise go to IDLE.
- Aborted or timed-out batches never update `latency_avg`, `latency_min` or `latency_max`.
- `abort` in any state goes to IDLE next cycle with `flash`=0. Outputs are held and `timeout` is unchanged.
- `start` and `abort` in the same cycle: `abort` wins.
- `start` while busy is ignored.

## Timing
- Reset values: state IDLE; all outputs 0 (`flash`, `busy`, `done`, `timeout`, all latencies, `sample_idx`).
- µs tick: a prescaler is cleared on every state entry. The first tick comes US_DIV cycles after entry, then every US_DIV cycles.
- Counter semantics: the counter holds the number of ticks elapsed. A `light_on` seen at cycle k after FLASH entry yields floor(k/US_DIV).
- `flash` is registered. It rises on the cycle the state becomes FLASH and falls on the cycle the state becomes RECORD.
- `done` asserts the cycle after RECORD of the final sample, together with the updated averages.
- `busy` is registered from the state: it goes high the cycle after `start` and low on IDLE entry.

## Structure
- `latency_meter_pkg` holds the state enum `lm_state_t`.
- One sub-module, `us_ticker` (parameter US_DIV; ports `clk`, `reset`, `clear`, `tick`), provides the prescaler.
- Saturation at TIMEOUT_US is compared in µs ticks. The counter does not wrap.

## Test plan
Bench parameters: US_DIV=4, CNT_W=12, AVG_LOG2=2, SETTLE_US=10, TIMEOUT_US=100.
- Reset, then `start`. The sensor model raises `light_on` 20 cycles after `flash` rises and drops it 8 cycles after `flash` falls, for 4 samples. Required: `latency_last`=5 each time, `done` pulse once, avg/min/max=5, `sample_idx`=4.
- Sensor delays of 12, 20, 28, 41 cycles. Required: samples 3, 5, 7, 10; avg=6 (25>>2); min=3; max=10.
- `light_on` never rises. Required: `timeout`=1 and IDLE 400 cycles after FLASH entry; `flash`=0; avg/min/max keep their previous values.
- `light_on` stuck high from `start`. Required: DARK times out at 100 µs and `flash` never asserts.
- `continuous`=1. Required: back-to-back `done` pulses and `busy` never drops; `abort` mid-FLASH drops `flash` next cycle and leaves `busy`=0.
- `reset` asserted mid-FLASH. Required: all outputs 0 next cycle; a `start` pulse during `busy` has no effect.
